// File: rtl/out_uart_tx.sv
// ---------------------------------------------------------------------------
// out_uart_tx
//
// Buffered 8N1 UART transmitter for the core's output path. The core pushes
// result bytes into a small circular FIFO. A serializer drains the FIFO onto
// txd, so the core only waits when the FIFO is full.
//
// Parameters
//   CLK_PER_HALF_BIT : clocks per half bit; one bit = 2*CLK_PER_HALF_BIT clocks
//   DEPTH_LOG2       : FIFO depth is 2**DEPTH_LOG2 bytes
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous, active-high reset
//   wr_en    in   push request
//   wr_data  in   byte to push
//   full     out  FIFO holds 2**DEPTH_LOG2 bytes (registered)
//   empty    out  FIFO holds 0 bytes (registered)
//   busy     out  serializer is in START, DATA or STOP
//   ovf      out  sticky overflow flag (0 unless OUT_UART_TX_OVF_EN)
//   txd      out  serial line, idle high, driven from a flop
//
// Push handshake: there is no ready signal. A push is accepted on a rising
// edge iff wr_en is 1 and full (the registered value in that cycle) is 0;
// a push presented while full is 1 is dropped and leaves the FIFO untouched.
//
// Build option
//   OUT_UART_TX_OVF_EN : when defined, ovf latches 1 on the edge after any
//                        push attempted while full and holds until rst.
//                        When undefined, ovf is tied to 0.
//
// The serializer state is held in state_q (type state_t) for hierarchical
// observation by checkers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module out_uart_tx #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int DEPTH_LOG2       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf,
    output logic       txd
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    // A depth-1 FIFO still needs a 1-bit pointer to index the storage.
    localparam int PTR_W    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int CNT_FW   = DEPTH_LOG2 + 1;
    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int TMR_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BIT_CLKS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_FW-1:0] CNT_FULL = CNT_FW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // FIFO state
    // -----------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;

    logic              push;
    logic              pop;
    logic [7:0]        head;

    // -----------------------------------------------------------------------
    // Serializer state
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;
    logic [2:0]        idx_q,   idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q,   txd_d;
    logic              bit_done;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // FIFO next-state
    // -----------------------------------------------------------------------
    assign push = wr_en && !full_q;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase

        // Flags come from the next count so they are valid right after the
        // edge that changes the occupancy.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset: contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer next-state and outputs
    // -----------------------------------------------------------------------
    assign bit_done = (tmr_q == TMR_LAST);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                tmr_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = head;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_done) begin
                    tmr_d   = '0;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    tmr_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Shift right so the bit on the line is always
                        // shift_q[0]; the next bit is shift_q[1].
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    tmr_d = '0;
                    if (!empty_q) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shift_d = head;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                tmr_d   = '0;
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Overflow flag
    // -----------------------------------------------------------------------
`ifdef OUT_UART_TX_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = (state_q != S_IDLE);
    assign txd   = txd_q;

endmodule

// File: tb/tb_out_uart_tx.sv
`timescale 1ns/1ps

module tb_out_uart_tx;

  localparam int H     = 4;
  localparam int BIT   = 2 * H;
  localparam int FRAME = 10 * BIT;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;

`ifdef OUT_UART_TX_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, ovf, txd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  out_uart_tx #(
    .CLK_PER_HALF_BIT(H),
    .DEPTH_LOG2      (DL2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .full   (full),
    .empty  (empty),
    .busy   (busy),
    .ovf    (ovf),
    .txd    (txd)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- line decoder
  // Independent 8N1 receiver: samples mid-bit on the falling clock edge and
  // logs every decoded byte, every start time, and framing errors.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;
  int         mon_pos   = -1;
  logic [7:0] mon_byte  = 8'h00;

  always @(negedge clk) begin
    int k;
    if (rst === 1'b1) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (txd === 1'b0) begin
        mon_pos = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_pos = mon_pos + 1;
      if (mon_pos % BIT == BIT / 2) begin
        k = mon_pos / BIT;
        if (k == 0) begin
          if (txd !== 1'b0) frame_err = frame_err + 1;
        end else if (k <= 8) begin
          mon_byte[k-1] = txd;
        end else begin
          if (txd !== 1'b1) frame_err = frame_err + 1;
          rx_q.push_back(mon_byte);
          mon_pos = -1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output logic ok);
    int n;
    n = 0;
    while ((busy !== 1'b0 || empty !== 1'b1) && n < budget) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0 && empty === 1'b1);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    wr_en = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    total++; if (txd   !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if (busy  !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full  !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (ovf   !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte(input logic [7:0] b, input string name);
    logic [9:0] line;
    int         rx_base;
    int         err_base;
    logic       ok;
    line     = {1'b1, b, 1'b0};
    rx_base  = rx_q.size();
    err_base = frame_err;

    push_one(b);  // now just after edge 0
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL %s_empty_e0 got=%b exp=0", name, empty); end
    total++; if (txd !== 1'b1)   begin bad++; $display("FAIL %s_txd_e0 got=%b exp=1", name, txd); end
    tick();       // just after edge 1: start bit on the line
    for (int c = 0; c < FRAME; c++) begin
      total++;
      if (txd !== line[c / BIT]) begin
        bad++; $display("FAIL %s_line c=%0d got=%b exp=%b", name, c, txd, line[c / BIT]);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL %s_busy c=%0d got=%b exp=1", name, c, busy);
      end
      if (c == 1) begin
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL %s_empty_e2 got=%b exp=1", name, empty); end
      end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%b exp=0", name, busy); end
    total++; if (txd !== 1'b1)  begin bad++; $display("FAIL %s_txd_end got=%b exp=1", name, txd); end
    wait_drain(50, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL %s_drain busy=%b empty=%b exp idle", name, busy, empty); end
    total++;
    if (rx_q.size() != rx_base + 1) begin
      bad++; $display("FAIL %s_rx_count got=%0d exp=1", name, rx_q.size() - rx_base);
    end else if (rx_q[rx_base] !== b) begin
      bad++; $display("FAIL %s_rx_byte got=%h exp=%h", name, rx_q[rx_base], b);
    end
    total++; if (frame_err != err_base) begin bad++; $display("FAIL %s_framing got=%0d exp=0", name, frame_err - err_base); end
  endtask

  task automatic test_back_to_back();
    int   rx_base, st_base, err_base;
    logic ok;
    rx_base  = rx_q.size();
    st_base  = start_q.size();
    err_base = frame_err;
    push_one(8'h00);
    push_one(8'hFF);
    wait_drain(4 * FRAME, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_drain busy=%b empty=%b exp idle", busy, empty); end
    total++;
    if (start_q.size() != st_base + 2) begin
      bad++; $display("FAIL b2b_starts got=%0d exp=2", start_q.size() - st_base);
    end else if (start_q[st_base+1] - start_q[st_base] != FRAME) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", start_q[st_base+1] - start_q[st_base], FRAME);
    end
    total++;
    if (rx_q.size() != rx_base + 2) begin
      bad++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_q.size() - rx_base);
    end else if (rx_q[rx_base] !== 8'h00 || rx_q[rx_base+1] !== 8'hFF) begin
      bad++; $display("FAIL b2b_rx_bytes got=%h,%h exp=00,ff", rx_q[rx_base], rx_q[rx_base+1]);
    end
    total++; if (frame_err != err_base) begin bad++; $display("FAIL b2b_framing got=%0d exp=0", frame_err - err_base); end
  endtask

  task automatic test_overflow();
    logic [7:0] b[6];
    logic [7:0] exp_q[$];
    int         rx_base, err_base;
    logic       ok;
    rx_base  = rx_q.size();
    err_base = frame_err;
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom_range(0, 255));
    // One byte leaves for the serializer one clock after the first push,
    // so DEPTH + 1 bytes fit; the sixth is dropped.
    for (int k = 0; k < DEPTH + 1; k++) exp_q.push_back(b[k]);

    for (int k = 0; k < 6; k++) begin
      wr_en   = 1'b1;
      wr_data = b[k];
      tick();  // just after edge k
      total++;
      if (full !== (k >= 4)) begin bad++; $display("FAIL ovf_full_e%0d got=%b exp=%b", k, full, (k >= 4)); end
      if (k <= 4) begin
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early_e%0d got=%b exp=0", k, ovf); end
      end
    end
    wr_en = 1'b0;
    tick();    // just after edge 6
    total++; if (ovf !== OVF_ON) begin bad++; $display("FAIL ovf_flag_e6 got=%b exp=%b", ovf, OVF_ON); end
    wait_drain(8 * FRAME, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ovf_drain busy=%b empty=%b exp idle", busy, empty); end
    total++; if (ovf !== OVF_ON) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, OVF_ON); end
    total++;
    if (rx_q.size() != rx_base + exp_q.size()) begin
      bad++; $display("FAIL ovf_rx_count got=%0d exp=%0d", rx_q.size() - rx_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
      total++;
      if (rx_q[rx_base+i] !== exp_q[i]) begin bad++; $display("FAIL ovf_rx_%0d got=%h exp=%h", i, rx_q[rx_base+i], exp_q[i]); end
    end
    total++; if (frame_err != err_base) begin bad++; $display("FAIL ovf_framing got=%0d exp=0", frame_err - err_base); end
    pulse_reset();
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
  endtask

  task automatic test_pointer_wrap();
    logic [7:0] exp_q[$];
    int         rx_base, err_base;
    logic       ok;
    rx_base  = rx_q.size();
    err_base = frame_err;
    for (int i = 1; i <= 10; i++) begin
      push_one(8'(i));
      exp_q.push_back(8'(i));
      repeat (FRAME - 1) tick();
    end
    wait_drain(4 * FRAME, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_drain busy=%b empty=%b exp idle", busy, empty); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", ovf); end
    total++;
    if (rx_q.size() != rx_base + exp_q.size()) begin
      bad++; $display("FAIL wrap_rx_count got=%0d exp=%0d", rx_q.size() - rx_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
      total++;
      if (rx_q[rx_base+i] !== exp_q[i]) begin bad++; $display("FAIL wrap_rx_%0d got=%h exp=%h", i, rx_q[rx_base+i], exp_q[i]); end
    end
    total++; if (frame_err != err_base) begin bad++; $display("FAIL wrap_framing got=%0d exp=0", frame_err - err_base); end
  endtask

  task automatic test_random_burst();
    logic [7:0] exp_q[$];
    logic [7:0] v;
    int         n, rx_base, err_base;
    logic       ok;
    for (int it = 0; it < 5; it++) begin
      exp_q.delete();
      rx_base  = rx_q.size();
      err_base = frame_err;
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        v       = 8'($urandom_range(0, 255));
        wr_en   = 1'b1;
        wr_data = v;
        if (k < DEPTH + 1) exp_q.push_back(v);
        tick();
      end
      wr_en = 1'b0;
      tick();
      total++;
      if (ovf !== (OVF_ON && n > DEPTH + 1)) begin
        bad++; $display("FAIL burst%0d_ovf n=%0d got=%b exp=%b", it, n, ovf, (OVF_ON && n > DEPTH + 1));
      end
      wait_drain(8 * FRAME, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL burst%0d_drain busy=%b empty=%b exp idle", it, busy, empty); end
      total++;
      if (rx_q.size() != rx_base + exp_q.size()) begin
        bad++; $display("FAIL burst%0d_rx_count got=%0d exp=%0d", it, rx_q.size() - rx_base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && rx_base + i < rx_q.size(); i++) begin
        total++;
        if (rx_q[rx_base+i] !== exp_q[i]) begin bad++; $display("FAIL burst%0d_rx_%0d got=%h exp=%h", it, i, rx_q[rx_base+i], exp_q[i]); end
      end
      total++; if (frame_err != err_base) begin bad++; $display("FAIL burst%0d_framing got=%0d exp=0", it, frame_err - err_base); end
      pulse_reset();
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b0;
    int         rx_base, st_base, high_errs;
    b0 = 8'($urandom_range(0, 255));
    push_one(b0);                         // edge 0
    push_one(8'($urandom_range(0, 255))); // edge 1
    push_one(8'($urandom_range(0, 255))); // edge 2
    // Start bit began at edge 1; data bit 3 occupies edges 33..40.
    repeat (33) tick();                   // just after edge 35
    total++; if (txd !== b0[3]) begin bad++; $display("FAIL midrst_bit3 got=%b exp=%b", txd, b0[3]); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL midrst_queued got=%b exp=0", empty); end
    rst = 1'b1;
    tick();                               // just after edge 36
    total++; if (txd !== 1'b1)   begin bad++; $display("FAIL midrst_txd got=%b exp=1", txd); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%b exp=1", empty); end
    rst = 1'b0;
    rx_base   = rx_q.size();
    st_base   = start_q.size();
    high_errs = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) high_errs++;
    end
    total++; if (high_errs != 0) begin bad++; $display("FAIL midrst_quiet got=%0d active cycles exp=0", high_errs); end
    total++;
    if (start_q.size() != st_base || rx_q.size() != rx_base) begin
      bad++; $display("FAIL midrst_no_frames got starts=%0d bytes=%0d exp=0,0", start_q.size() - st_base, rx_q.size() - rx_base);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    test_reset();
    test_single_byte(8'h55, "single55");
    test_single_byte(8'($urandom_range(0, 255)), "single_rand");
    test_back_to_back();
    test_overflow();
    test_pointer_wrap();
    test_random_burst();
    test_reset_mid_frame();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
